// File: rtl/banco_write_stage.sv
// Registered write-back stage for the multicycle MIPS register bank: selects a source,
// canonicalises SP/SLT values, waits on multi-cycle sources and issues one bank write.
module banco_write_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSRC    = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned SP_SEL  = 5,
  parameter int unsigned SP_INIT = 227,
  parameter int unsigned LT_SEL  = 7,
  parameter logic [(1 << SEL_W)-1:0] WAIT_MASK = 8'b0001_1000,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic [REG_AW-1:0]      dest,
  input  logic                   req,
  input  logic                   src_ready,
  output logic [DATA_W-1:0]      WriteData,
  output logic [REG_AW-1:0]      WriteReg,
  output logic                   RegWrite,
  output logic                   busy,
  output logic                   ack,
  output logic                   err
);

  localparam int unsigned NSLOT = 1 << SEL_W;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t            state;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] src_arr [NSLOT];
  logic [NSLOT-1:0]  legal;
  logic [SEL_W-1:0]  cap_sel_c;
  logic [DATA_W-1:0] cap_data_c;

  // Unpack sources; select codes beyond NSRC read zero and are flagged illegal.
  for (genvar i = 0; i < NSLOT; i++) begin : g_src
    if (i < NSRC) begin : g_real
      assign src_arr[i] = src_data[i*DATA_W +: DATA_W];
      assign legal[i]   = 1'b1;
    end else begin : g_pad
      assign src_arr[i] = '0;
      assign legal[i]   = 1'b0;
    end
  end

  // While waiting the request's select is held in sel_q; the live input may change.
  assign cap_sel_c = (state == S_WAIT) ? sel_q : sel;

  always_comb begin
    cap_data_c = src_arr[cap_sel_c];
    if (cap_sel_c == SEL_W'(SP_SEL)) begin
      cap_data_c = DATA_W'(SP_INIT);
    end else if (cap_sel_c == SEL_W'(LT_SEL)) begin
      cap_data_c = {{(DATA_W-1){1'b0}}, src_arr[cap_sel_c][0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sel_q     <= '0;
      cnt       <= '0;
      WriteData <= '0;
      WriteReg  <= '0;
      RegWrite  <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      ack      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            WriteReg <= dest;
            if (!legal[sel]) begin
              err <= 1'b1;
              ack <= 1'b1;
            end else if (WAIT_MASK[sel] && !src_ready) begin
              state <= S_WAIT;
              busy  <= 1'b1;
              sel_q <= sel;
              cnt   <= '0;
            end else begin
              WriteData <= cap_data_c;
              RegWrite  <= (dest != '0);
              ack       <= 1'b1;
              busy      <= 1'b1;
              state     <= S_WRITE;
            end
          end
        end
        S_WAIT: begin
          if (src_ready) begin
            WriteData <= cap_data_c;
            RegWrite  <= (WriteReg != '0);
            ack       <= 1'b1;
            state     <= S_WRITE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            ack   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/banco_write_stage.md
Name: banco_write_stage

Overview:
Registered write-back stage for the multicycle MIPS register bank. It selects one of NSRC write-data sources, forces the stack-pointer constant and the 1-bit SLT result into their canonical forms, and presents one registered write (data, register index, write strobe) to the bank per request. Sources that complete over several cycles (Hi/Lo from mult/div) are waited on via a ready handshake with a bounded timeout. Sits between the datapath source muxing and the register bank write port; driven by the control unit.

Parameters:
DATA_W, 32, width of every source and of WriteData
NSRC, 8, number of data sources (sel values 0..NSRC-1)
SEL_W, 3, width of sel; must satisfy 2**SEL_W >= NSRC
REG_AW, 5, register index width
SP_SEL, 5, sel value that writes the constant SP_INIT instead of source data
SP_INIT, 227, stack start value written when sel == SP_SEL
LT_SEL, 7, sel value whose source is reduced to bit 0, zero-extended
WAIT_MASK, 8'b0001_1000, bit i set = source i needs src_ready before capture (Hi=3, Lo=4)
TIMEOUT, 64, max cycles spent waiting for src_ready; 8-bit counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
src_data  in  NSRC*DATA_W  flattened sources, source i at bits [i*DATA_W +: DATA_W]
sel  in  SEL_W  source select, sampled with req
dest  in  REG_AW  destination register, sampled with req
req  in  1  write request, one-cycle pulse, honoured only in IDLE
src_ready  in  1  multi-cycle source result valid (mult/div done)
WriteData  out  DATA_W  registered write data to bank
WriteReg  out  REG_AW  registered destination index
RegWrite  out  1  bank write strobe, one cycle
busy  out  1  high in WAIT and WRITE
ack  out  1  one-cycle pulse, request completed (with or without write)
err  out  1  sticky: timeout or illegal sel; cleared only by reset

Behaviour:
- Reset (asynchronous, active-low): state IDLE; WriteData=0, WriteReg=0, RegWrite=0, busy=0, ack=0, err=0, timeout counter=0. Reset asserted mid-operation aborts the request; no write is issued.
- States: IDLE, WAIT, WRITE.
- IDLE, req=1 at edge: latch sel and dest into WriteReg.
  - sel >= NSRC: set err, pulse ack next cycle, RegWrite stays 0, remain IDLE.
  - WAIT_MASK[sel]=1 and src_ready=0: go to WAIT, clear counter.
  - otherwise: capture data and go to WRITE.
- Data capture rule: sel==SP_SEL -> SP_INIT; sel==LT_SEL -> {DATA_W-1 zeros, src bit 0}; else src_data slice. The value is captured at the transition edge and held stable while in WRITE.
- WAIT: on each edge with src_ready=1, capture data and go to WRITE. Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ready: set err, pulse ack, return to IDLE with no write.
- WRITE (exactly one cycle): RegWrite=1 unless WriteReg==0, since $zero is never written. ack=1 in both cases. Next state IDLE.
- Latency: req with a ready source -> RegWrite in the cycle after req (1 cycle). With a waited source -> RegWrite in the cycle after src_ready is seen.
- req while busy: ignored, no queueing. The control unit must not reissue until ack.
- RegWrite and ack are never high outside WRITE, except the error ack pulse. WriteData and WriteReg keep their last value in IDLE.
- req and src_ready both high in IDLE for a waited sel: proceed directly to WRITE, never entering WAIT.

Test Plan:
- Reset, then req sel=0 dest=8 src0=32'h1234_5678 -> next cycle RegWrite=1, WriteReg=8, WriteData=32'h1234_5678, ack=1; following cycle RegWrite=0, busy=0.
- req sel=5 dest=29 (src5=32'hFFFF_FFFF) -> WriteData=227; req sel=7 src7=32'hFFFF_FFFE -> WriteData=0; src7=32'h3 -> WriteData=1.
- req sel=3 with src_ready=0, raise src_ready after 4 cycles with src3=32'hDEAD_BEEF -> busy high for 5 cycles, then one cycle with RegWrite=1, WriteData=32'hDEAD_BEEF.
- req sel=4 with src_ready held low -> after TIMEOUT cycles err=1 and one ack pulse, RegWrite never asserted; a second req while in WAIT is ignored.
- req dest=0 sel=1 -> ack=1, RegWrite=0. Repeat with NSRC=6 and sel=6 -> err=1, no write.
- Assert reset (low) while in WAIT -> all outputs 0 immediately, without waiting for a clock edge; after release a fresh req sel=0 completes normally.
